// File: rtl/fetch_pc_predictor.sv
// Fetch-stage PC generator with a direct-mapped BTB and 2-bit bimodal counters.
// Lookup is combinational from the registered pc; training from EX lands at the clock edge.
module fetch_pc_predictor #(
  parameter int                    PC_WIDTH    = 32,
  parameter int                    BTB_ENTRIES = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                upd_valid,
  input  logic [PC_WIDTH-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [PC_WIDTH-1:0] upd_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                pred_valid,
  output logic                pred_taken,
  output logic [PC_WIDTH-1:0] pred_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_WIDTH - IDX_W - 2;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [PC_WIDTH-1:0]    target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IDX_W-1:0]    look_idx;
  logic [TAG_W-1:0]    look_tag;
  logic                look_hit;
  logic [IDX_W-1:0]    upd_idx;
  logic [TAG_W-1:0]    upd_tag;
  logic                upd_hit;
  logic [PC_WIDTH-1:0] next_pc;

  assign look_idx = pc[IDX_W+1:2];
  assign look_tag = pc[PC_WIDTH-1:IDX_W+2];
  assign look_hit = valid_q[look_idx] && (tag_q[look_idx] == look_tag);

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[PC_WIDTH-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign pred_valid  = look_hit;
  assign pred_taken  = look_hit && ctr_q[look_idx][1];
  assign pred_target = look_hit ? target_q[look_idx] : '0;

  // Redirect wins over stall so a mispredict is never lost behind a hazard.
  always_comb begin
    next_pc = pc + PC_WIDTH'(4);
    if (redirect) begin
      next_pc = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    end else if (stall) begin
      next_pc = pc;
    end else if (pred_taken) begin
      next_pc = pred_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  // Table writes see the pre-edge contents, so a same-cycle lookup returns old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          target_q[upd_idx] <= upd_target;
          if (ctr_q[upd_idx] != 2'b11) begin
            ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
          end
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_predictor.sv
// Bench for fetch_pc_predictor: directed scenarios then random traffic,
// all checked against an arithmetic model of the BTB and fetch PC.
module tb_fetch_pc_predictor;

  localparam bit [31:0] N = 32'd16;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit [31:0] m_pc;
  bit        m_v   [16];
  bit [31:0] m_tag [16];
  bit [31:0] m_tgt [16];
  int        m_cnt [16];

  fetch_pc_predictor #(.PC_WIDTH(32), .BTB_ENTRIES(16), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .pc          (pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_target (pred_target)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_cnt[i] = 1;
    end
  endtask

  task automatic set_idle();
    stall = 0; redirect = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
  endtask

  // One clock: check lookup outputs, drive inputs, advance model after the edge.
  task automatic step(input bit s, input bit r, input bit [31:0] rpc,
                      input bit uv, input bit [31:0] upc, input bit ut, input bit [31:0] utgt);
    int        li, ui;
    bit        hit, uhit, ptk;
    bit [31:0] ptgt;
    li   = int'((m_pc / 4) % N);
    hit  = m_v[li] && (m_tag[li] == m_pc / (4 * N));
    ptk  = hit && (m_cnt[li] >= 2);
    ptgt = hit ? m_tgt[li] : 32'h0;
    chk("pc", pc, m_pc);
    chk("pred_valid", 32'(pred_valid), 32'(hit));
    chk("pred_taken", 32'(pred_taken), 32'(ptk));
    chk("pred_target", pred_target, ptgt);
    stall = s; redirect = r; redirect_pc = rpc;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    @(posedge clk);
    #1;
    if (r)        m_pc = rpc & 32'hFFFF_FFFC;
    else if (s)   m_pc = m_pc;
    else if (ptk) m_pc = ptgt;
    else          m_pc = m_pc + 32'd4;
    if (uv) begin
      ui   = int'((upc / 4) % N);
      uhit = m_v[ui] && (m_tag[ui] == upc / (4 * N));
      if (uhit) begin
        if (ut) begin
          m_tgt[ui] = utgt;
          if (m_cnt[ui] < 3) m_cnt[ui] = m_cnt[ui] + 1;
        end else if (m_cnt[ui] > 0) begin
          m_cnt[ui] = m_cnt[ui] - 1;
        end
      end else if (ut) begin
        m_v[ui] = 1'b1; m_tag[ui] = upc / (4 * N); m_tgt[ui] = utgt; m_cnt[ui] = 2;
      end
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic go(input bit [31:0] a);
    step(0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic train(input bit [31:0] a, input bit t, input bit [31:0] tgt);
    step(0, 0, 0, 1, a, t, tgt);
  endtask

  // Reset asserted between edges must take effect immediately.
  task automatic mid_reset();
    set_idle();
    #1 rst = 1'b1;
    #1;
    model_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_pred_valid", 32'(pred_valid), 32'h0);
    chk("rst_pred_target", pred_target, 32'h0);
    #1 rst = 1'b0;
  endtask

  initial begin
    set_idle();
    model_reset();
    rst = 1'b1;
    #12;
    chk("por_pc", pc, 32'h0);
    chk("por_pred_valid", 32'(pred_valid), 32'h0);
    rst = 1'b0;

    // Sequential fetch, then reset mid-operation
    repeat (3) idle_step();
    chk("seq_pc_c", pc, 32'hC);
    mid_reset();
    repeat (4) idle_step();
    chk("seq_pc_10", pc, 32'h10);

    // Stall holds, then resumes
    repeat (3) step(1, 0, 0, 0, 0, 0, 0);
    chk("stall_hold", pc, 32'h10);
    idle_step();
    chk("stall_resume", pc, 32'h14);

    // Redirect beats stall and clears the low bits
    step(1, 1, 32'h203, 0, 0, 0, 0);
    chk("redirect_pc", pc, 32'h200);

    // Allocation and taken prediction
    train(32'h40, 1, 32'h100);
    go(32'h40);
    chk("alloc_valid", 32'(pred_valid), 32'h1);
    chk("alloc_taken", 32'(pred_taken), 32'h1);
    idle_step();
    chk("alloc_next", pc, 32'h100);

    // Not-taken miss creates nothing
    train(32'h44, 0, 32'h300);
    go(32'h44);
    chk("nt_miss_valid", 32'(pred_valid), 32'h0);

    // Hysteresis: 10 -> 11 -> 10 (taken) -> 01 (not taken)
    repeat (3) train(32'h40, 1, 32'h100);
    train(32'h40, 0, 32'h0);
    go(32'h40);
    chk("hyst_taken", 32'(pred_taken), 32'h1);
    train(32'h40, 0, 32'h0);
    go(32'h40);
    chk("hyst_valid", 32'(pred_valid), 32'h1);
    chk("hyst_not_taken", 32'(pred_taken), 32'h0);
    idle_step();
    chk("hyst_next", pc, 32'h44);

    // Aliasing at index 0
    go(32'h80);
    chk("alias_miss", 32'(pred_valid), 32'h0);
    train(32'h80, 1, 32'h300);
    go(32'h40);
    chk("alias_evicted", 32'(pred_valid), 32'h0);
    go(32'h80);
    chk("alias_new_target", pred_target, 32'h300);

    // Same-cycle allocate at the looked-up index returns old contents
    go(32'h0);
    chk("conflict_old", 32'(pred_valid), 32'h0);
    train(32'h0, 1, 32'h500);
    chk("conflict_no_predict", pc, 32'h4);
    go(32'h0);
    chk("conflict_new", 32'(pred_valid), 32'h1);

    // Wrap at the top of the address space
    go(32'hFFFF_FFFC);
    chk("wrap_miss", 32'(pred_valid), 32'h0);
    idle_step();
    chk("wrap_pc", pc, 32'h0);

    // Random traffic over a small address window so entries hit and alias
    for (int i = 0; i < 400; i++) begin
      bit        s, r, uv, ut;
      bit [31:0] rpc, upc, utgt;
      s    = ($urandom_range(0, 3) == 0);
      r    = ($urandom_range(0, 7) == 0);
      rpc  = 32'($urandom_range(0, 511));
      uv   = ($urandom_range(0, 1) == 1);
      upc  = 32'($urandom_range(0, 127)) << 2;
      if ($urandom_range(0, 15) == 0) upc = upc | 32'hFFFF_FE00;
      ut   = ($urandom_range(0, 2) != 0);
      utgt = 32'($urandom_range(0, 127)) << 2;
      step(s, r, rpc, uv, upc, ut, utgt);
      if (i == 200) mid_reset();
    end
    set_idle();
    idle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
